// File: rtl/graphics_pkg.sv
// Shared constants, move encodings and controller state type for the sprite controller.
package graphics_pkg;

  localparam int unsigned DefNumSprites = 4;
  localparam int unsigned DefHFrame     = 640;
  localparam int unsigned DefVFrame     = 480;
  localparam int unsigned DefSpriteW    = 16;
  localparam int unsigned DefSpriteH    = 16;
  localparam int unsigned DefStep       = 1;
  localparam int unsigned DefCoordW     = 10;

  // x: Dec = left, Inc = right; y: Dec = down, Inc = up.
  typedef enum logic [1:0] {
    MoveDec   = 2'd0,
    MoveStay  = 2'd1,
    MoveInc   = 2'd2,
    MoveStay2 = 2'd3
  } move_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSnap = 2'd1,
    StEmit = 2'd2
  } ctrl_state_e;

  function automatic logic move_active(input logic [1:0] code);
    return (move_e'(code) == MoveDec) || (move_e'(code) == MoveInc);
  endfunction

endpackage

// File: rtl/sprite_axis_ctrl.sv
// One axis of one sprite: saturating position with a one-move-per-frame lockout.
module sprite_axis_ctrl
  import graphics_pkg::*;
#(
  parameter int unsigned FRAME   = DefHFrame,
  parameter int unsigned SPRITE  = DefSpriteW,
  parameter int unsigned STEP    = DefStep,
  parameter int unsigned COORD_W = DefCoordW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         move,
  input  logic               toggle,
  output logic [COORD_W-1:0] pos,
  output logic               changed
);

  // One extra bit so the decrement compare never wraps below zero.
  localparam logic [COORD_W:0] PosMin = (COORD_W + 1)'(SPRITE / 2);
  localparam logic [COORD_W:0] PosMax = (COORD_W + 1)'(FRAME - 1 - SPRITE / 2);
  localparam logic [COORD_W:0] PosRst = (COORD_W + 1)'(FRAME / 2);
  localparam logic [COORD_W:0] StepW  = (COORD_W + 1)'(STEP);

  logic [COORD_W:0] pos_q, pos_d, target;
  logic             moved_q, moved_d, accept;

  always_comb begin
    target = pos_q;
    case (move_e'(move))
      MoveDec: target = (pos_q < PosMin + StepW) ? PosMin : pos_q - StepW;
      MoveInc: target = (pos_q + StepW > PosMax) ? PosMax : pos_q + StepW;
      default: target = pos_q;
    endcase
    accept  = move_active(move) && !moved_q;
    pos_d   = accept ? target : pos_q;
    changed = (pos_d != pos_q);
    // A toggle wins over a same-edge move for the flag; the move itself still lands.
    moved_d = toggle ? 1'b0 : (moved_q | accept);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= PosRst;
      moved_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      moved_q <= moved_d;
    end
  end

  assign pos = pos_q[COORD_W-1:0];

endmodule

// File: rtl/multi_sprite_controller.sv
// Per-frame sprite movement with a snapshot-and-emit update stream to the back-buffer writer.
module multi_sprite_controller
  import graphics_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = DefNumSprites,
  parameter int unsigned H_FRAME     = DefHFrame,
  parameter int unsigned V_FRAME     = DefVFrame,
  parameter int unsigned SPRITE_W    = DefSpriteW,
  parameter int unsigned SPRITE_H    = DefSpriteH,
  parameter int unsigned STEP        = DefStep,
  parameter int unsigned COORD_W     = DefCoordW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           active_frame,
  input  logic [2*NUM_SPRITES-1:0]       x_move,
  input  logic [2*NUM_SPRITES-1:0]       y_move,
  output logic [COORD_W*NUM_SPRITES-1:0] pos_x,
  output logic [COORD_W*NUM_SPRITES-1:0] pos_y,
  output logic                           upd_valid,
  input  logic                           upd_ready,
  output logic [3:0]                     upd_idx,
  output logic [COORD_W-1:0]             upd_x,
  output logic [COORD_W-1:0]             upd_y,
  output logic                           upd_frame,
  output logic                           busy,
  output logic                           overrun
);

  logic [COORD_W-1:0]     live_x [NUM_SPRITES];
  logic [COORD_W-1:0]     live_y [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] chg_x, chg_y, chg;
  logic                   toggle;

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    sprite_axis_ctrl #(
      .FRAME   (H_FRAME),
      .SPRITE  (SPRITE_W),
      .STEP    (STEP),
      .COORD_W (COORD_W)
    ) u_axis_x (
      .clk     (clk),
      .rst     (rst),
      .move    (x_move[2*i +: 2]),
      .toggle  (toggle),
      .pos     (live_x[i]),
      .changed (chg_x[i])
    );
    sprite_axis_ctrl #(
      .FRAME   (V_FRAME),
      .SPRITE  (SPRITE_H),
      .STEP    (STEP),
      .COORD_W (COORD_W)
    ) u_axis_y (
      .clk     (clk),
      .rst     (rst),
      .move    (y_move[2*i +: 2]),
      .toggle  (toggle),
      .pos     (live_y[i]),
      .changed (chg_y[i])
    );
    assign pos_x[i*COORD_W +: COORD_W] = live_x[i];
    assign pos_y[i*COORD_W +: COORD_W] = live_y[i];
  end

  assign chg = chg_x | chg_y;

  ctrl_state_e            state_q, state_d;
  logic                   af_q, pending_q, pending_d, overrun_q, overrun_d;
  logic                   upd_valid_q, upd_valid_d, upd_frame_q, upd_frame_d;
  logic [3:0]             upd_idx_q, upd_idx_d;
  logic [COORD_W-1:0]     upd_x_q, upd_x_d, upd_y_q, upd_y_d;
  logic [NUM_SPRITES-1:0] dirty_q, dirty_d, snap_dirty_q, snap_dirty_d;
  logic [COORD_W-1:0]     snap_x_q [NUM_SPRITES];
  logic [COORD_W-1:0]     snap_y_q [NUM_SPRITES];
  logic                   snap_load;

  logic                   sel_found;
  logic [3:0]             sel_idx;
  logic [COORD_W-1:0]     sel_x, sel_y;
  logic [NUM_SPRITES-1:0] sel_onehot;

  assign toggle = active_frame ^ af_q;

  // Lowest-index dirty sprite in the snapshot; the descending loop leaves the lowest last.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_x      = '0;
    sel_y      = '0;
    sel_onehot = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (snap_dirty_q[i]) begin
        sel_found     = 1'b1;
        sel_idx       = 4'(i);
        sel_x         = snap_x_q[i];
        sel_y         = snap_y_q[i];
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | (toggle && (state_q != StIdle));
    overrun_d    = overrun_q | (toggle && (state_q != StIdle));
    upd_valid_d  = upd_valid_q;
    upd_frame_d  = upd_frame_q;
    upd_idx_d    = upd_idx_q;
    upd_x_d      = upd_x_q;
    upd_y_d      = upd_y_q;
    dirty_d      = dirty_q | chg;
    snap_dirty_d = snap_dirty_q;
    snap_load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (toggle) begin
          state_d     = StSnap;
          upd_frame_d = ~active_frame;
        end
      end
      StSnap: begin
        snap_load    = 1'b1;
        snap_dirty_d = dirty_q;
        dirty_d      = chg;
        state_d      = StEmit;
      end
      StEmit: begin
        // Valid low here means the first EMIT cycle; otherwise advance only on a handshake.
        if (!upd_valid_q || upd_ready) begin
          if (sel_found) begin
            upd_valid_d  = 1'b1;
            upd_idx_d    = sel_idx;
            upd_x_d      = sel_x;
            upd_y_d      = sel_y;
            snap_dirty_d = snap_dirty_q & ~sel_onehot;
          end else begin
            upd_valid_d = 1'b0;
            if (pending_d) begin
              state_d     = StSnap;
              pending_d   = 1'b0;
              upd_frame_d = ~active_frame;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      af_q         <= active_frame;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_frame_q  <= active_frame;
      upd_idx_q    <= '0;
      upd_x_q      <= '0;
      upd_y_q      <= '0;
      dirty_q      <= '1;
      snap_dirty_q <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        snap_x_q[i] <= '0;
        snap_y_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      af_q         <= active_frame;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      upd_valid_q  <= upd_valid_d;
      upd_frame_q  <= upd_frame_d;
      upd_idx_q    <= upd_idx_d;
      upd_x_q      <= upd_x_d;
      upd_y_q      <= upd_y_d;
      dirty_q      <= dirty_d;
      snap_dirty_q <= snap_dirty_d;
      if (snap_load) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          snap_x_q[i] <= live_x[i];
          snap_y_q[i] <= live_y[i];
        end
      end
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_idx   = upd_idx_q;
  assign upd_x     = upd_x_q;
  assign upd_y     = upd_y_q;
  assign upd_frame = upd_frame_q;
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;

endmodule

// File: doc/multi_sprite_controller.md
MULTI_SPRITE_CONTROLLER -- requirements
Module: multi_sprite_controller

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4, number of independently controlled sprites (1..16).
REQ-002 SHALL have parameter H_FRAME, default 640, horizontal frame size in pixels.
REQ-003 SHALL have parameter V_FRAME, default 480, vertical frame size in pixels.
REQ-004 SHALL have parameters SPRITE_W and SPRITE_H, default 16 each, sprite size in pixels.
REQ-005 SHALL have parameter STEP, default 1, pixels moved per accepted move.
REQ-006 SHALL have parameter COORD_W, default 10, coordinate width; it SHALL hold max(H_FRAME,V_FRAME)-1.
REQ-007 SHALL have clk  input  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have active_frame  input  1  displayed buffer, 0 = frame A, 1 = frame B.
REQ-010 SHALL have x_move  input  2*NUM_SPRITES  per-sprite code: 0 = left, 1 = stay, 2 = right, 3 = stay.
REQ-011 SHALL have y_move  input  2*NUM_SPRITES  per-sprite code: 0 = down, 1 = stay, 2 = up, 3 = stay.
REQ-012 SHALL have pos_x, pos_y  output  COORD_W*NUM_SPRITES  each  live sprite-centre coordinates.
REQ-013 SHALL have upd_valid  output  1, plus upd_ready  input  1: handshake to the frame writer.
REQ-014 SHALL have upd_idx  output  4, and upd_x, upd_y  output  COORD_W: update payload.
REQ-015 SHALL have upd_frame  output  1  buffer to update, equal to ~active_frame at snapshot.
REQ-016 SHALL have busy  output  1, and overrun  output  1  sticky flag.

Function
REQ-017 A frame toggle SHALL be detected as active_frame differing from its value registered on the previous cycle.
REQ-018 Each sprite axis SHALL accept at most one move per frame; a per-axis moved flag set by an accepted move SHALL be cleared on frame toggle.
REQ-019 A move SHALL be accepted when the code is 0 or 2 and the moved flag is clear; the position SHALL update on the next clk edge.
REQ-020 Moves SHALL saturate at bounds: x in [SPRITE_W/2, H_FRAME-1-SPRITE_W/2], y in [SPRITE_H/2, V_FRAME-1-SPRITE_H/2].
REQ-021 Bound arithmetic SHALL use COORD_W+1 bits so decrements never wrap below zero.
REQ-022 A move blocked at a bound SHALL still set the moved flag and SHALL NOT set dirty.
REQ-023 Any position change SHALL set that sprite's dirty bit.
REQ-024 FSM SHALL have states IDLE, SNAP, EMIT.
REQ-025 IDLE->SNAP on toggle: upd_frame captures ~active_frame.
REQ-026 SNAP SHALL, in one cycle, copy all positions and dirty bits to a snapshot and clear the live dirty bits, then go to EMIT.
REQ-027 Dirty bits set on the SNAP cycle itself SHALL remain set in the live copy.
REQ-028 EMIT SHALL present snapshot-dirty sprites in ascending index order, one per handshake.
REQ-029 upd_valid and payload SHALL stay stable until upd_valid and upd_ready are both high on a clk edge.
REQ-030 EMIT->IDLE on the cycle after the last transfer; with no dirty sprites, EMIT SHALL go to IDLE with no upd_valid.
REQ-031 busy SHALL be high in SNAP and EMIT.
REQ-032 A toggle during SNAP or EMIT SHALL set overrun, be queued, and cause SNAP directly after EMIT finishes; moved flags SHALL still clear at the toggle.
REQ-033 Simultaneous move and toggle on one edge: the move SHALL be accepted and the moved flag SHALL be cleared.

Reset
REQ-034 On rst, every sprite SHALL go to (H_FRAME/2, V_FRAME/2) with moved flags clear and dirty bits set.
REQ-035 On rst, FSM SHALL be IDLE with upd_valid, busy, overrun and the queued toggle at 0, upd_idx/upd_x/upd_y at 0, and the registered active_frame and upd_frame loaded from active_frame.
REQ-036 Reset during EMIT SHALL abort the transfer immediately with no further upd_valid.

Structure
REQ-037 Move encodings, FSM state enum and default frame/sprite constants SHALL reside in shared package graphics_pkg.
REQ-038 One axis of one sprite (position, moved flag, saturation) SHALL be sub-module sprite_axis_ctrl, instantiated 2*NUM_SPRITES times.

Verification (NUM_SPRITES=2, 640x480, 16x16, STEP=1)
REQ-039 Reset, toggle, upd_ready=1 -> two transfers (idx 0 then 1), each at (320,240), then IDLE.
REQ-040 Sprite 0 x_move=2 for 5 frames -> x=325, one step per frame; next toggle emits idx 0 only.
REQ-041 Sprite 1 at x=8, x_move=0 -> x stays 8, dirty stays clear; at y=471, y_move=2 -> y stays 471.
REQ-042 Hold upd_ready=0 for 10 cycles in EMIT -> upd_valid high and payload unchanged throughout.
REQ-043 Toggle twice within one EMIT -> overrun=1, second SNAP follows EMIT directly, no update lost.
REQ-044 Assert rst mid-EMIT -> upd_valid=0 next cycle, positions (320,240), busy=0.
